// File: rtl/gate_selftest_ctrl.sv
// Walks a/b through 00,01,10,11 and checks the 7 gate-bank outputs; run latency 4*(SETTLE+1) cycles.
// Does not backpressure: start is ignored while busy, and resp is only looked at on sample edges.
module gate_selftest_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] resp,
  output logic       stim_a,
  output logic       stim_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_vec,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] stim_q, stim_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [6:0] fail_vec_q, fail_vec_d;
  logic [2:0] err_count_q, err_count_d;

  logic       a, b;
  logic [6:0] exp_resp;
  logic [6:0] mism;

  // Reference truth table taken from the registered stimulus, so it matches what the bank sees.
  assign a        = stim_q[1];
  assign b        = stim_q[0];
  assign exp_resp = {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
  assign mism     = resp ^ exp_resp;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    stim_d      = stim_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_vec_d  = fail_vec_q;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_SETTLE;
          idx_d       = 2'd0;
          cnt_d       = SETTLE_LAST;
          stim_d      = 2'b00;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_vec_d  = '0;
          err_count_d = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) state_d = ST_SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_SAMPLE: begin
        fail_vec_d = fail_vec_q | mism;
        if (|mism) err_count_d = err_count_q + 3'd1;
        if (idx_q != 2'd3) begin
          // Next vector is driven from the same edge that samples the current one.
          idx_d   = idx_q + 2'd1;
          stim_d  = idx_q + 2'd1;
          cnt_d   = SETTLE_LAST;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_DONE;
          stim_d  = 2'b00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      stim_q      <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_vec_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_vec_q  <= fail_vec_d;
      err_count_q <= err_count_d;
    end
  end

  assign stim_a    = stim_q[1];
  assign stim_b    = stim_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q & (fail_vec_q == 7'd0);
  assign fail_vec  = fail_vec_q;
  assign err_count = err_count_q;

endmodule
